// File: rtl/decode_exec_pipe.sv
// Decode->execute pipeline register with valid/ready handshake, flush and global stall.
// Define DECODE_EXEC_PIPE_SKID_EN for the 2-entry skid variant (registered in_ready); default is single-entry.
module decode_exec_pipe #(
  parameter int LANES  = 4,
  parameter int CTRL_W = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_all,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [31:0]           in_pc,
  input  logic [31:0]           in_pc_plus4,
  input  logic [31:0]           in_imm,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [LANES*32-1:0]   in_rd1,
  input  logic [LANES*32-1:0]   in_rd2,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_pc_plus4,
  output logic [31:0]           out_imm,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [LANES*32-1:0]   out_rd1,
  output logic [LANES*32-1:0]   out_rd2,
  output logic [4:0]            out_rd,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [1:0]            occupancy
);

  localparam int DW = LANES * 32;
  localparam int PW = 4 * 32 + CTRL_W + 2 * DW + 15;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          r_in_rdy;
  logic [PW-1:0] r_main;
  logic [PW-1:0] w_in_bus;
  logic          w_acc;
  logic          w_iss;
  logic          w_ld_main_in;
  logic          w_clr;
`ifdef DECODE_EXEC_PIPE_SKID_EN
  logic [PW-1:0] r_skid;
  logic          w_ld_skid;
  logic          w_ld_main_skid;
`endif

  assign w_in_bus = {in_instr, in_pc, in_pc_plus4, in_imm, in_ctrl,
                     in_rd1, in_rd2, in_rd, in_rs1, in_rs2};
  assign {out_instr, out_pc, out_pc_plus4, out_imm, out_ctrl,
          out_rd1, out_rd2, out_rd, out_rs1, out_rs2} = r_main;

  assign w_acc = in_valid & in_ready;
  assign w_iss = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath load decode; stall outranks flush
  always_comb begin
    w_state_nxt  = r_state;
    w_ld_main_in = 1'b0;
    w_clr        = 1'b0;
`ifdef DECODE_EXEC_PIPE_SKID_EN
    w_ld_skid      = 1'b0;
    w_ld_main_skid = 1'b0;
`endif
    if (stall_all) begin
      w_state_nxt = r_state;
    end else if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_state_nxt  = ST_ONE;
            w_ld_main_in = 1'b1;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (w_acc && w_iss) begin
            w_state_nxt  = ST_ONE;
            w_ld_main_in = 1'b1;
          end else if (w_acc) begin
`ifdef DECODE_EXEC_PIPE_SKID_EN
            w_state_nxt = ST_TWO;
            w_ld_skid   = 1'b1;
`else
            w_state_nxt  = ST_ONE;
            w_ld_main_in = 1'b1;
`endif
          end else if (w_iss) begin
            w_state_nxt = ST_EMPTY;
          end else begin
            w_state_nxt = ST_ONE;
          end
        end
`ifdef DECODE_EXEC_PIPE_SKID_EN
        ST_TWO: begin
          // Skid entry moves to main on the issuing edge so there is no bubble
          if (w_iss) begin
            w_state_nxt    = ST_ONE;
            w_ld_main_skid = 1'b1;
          end else begin
            w_state_nxt = ST_TWO;
          end
        end
`endif
        default: begin
          w_state_nxt = ST_EMPTY;
          w_clr       = 1'b1;
        end
      endcase
    end
  end

  // Handshake and occupancy outputs
  always_comb begin
    out_valid = (r_state != ST_EMPTY) & ~stall_all;
    occupancy = r_state;
`ifdef DECODE_EXEC_PIPE_SKID_EN
    in_ready  = r_in_rdy & ~stall_all;
`else
    in_ready  = r_in_rdy & ~stall_all & ((r_state == ST_EMPTY) | out_ready);
`endif
  end

  // Ready flop: holds low through reset, rises on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_rdy <= 1'b0;
    end else begin
`ifdef DECODE_EXEC_PIPE_SKID_EN
      r_in_rdy <= (w_state_nxt != ST_TWO);
`else
      r_in_rdy <= 1'b1;
`endif
    end
  end

  // Main (oldest) entry payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= {PW{1'b0}};
    end else if (w_clr) begin
      r_main <= {PW{1'b0}};
    end else if (w_ld_main_in) begin
      r_main <= w_in_bus;
`ifdef DECODE_EXEC_PIPE_SKID_EN
    end else if (w_ld_main_skid) begin
      r_main <= r_skid;
`endif
    end else begin
      r_main <= r_main;
    end
  end

`ifdef DECODE_EXEC_PIPE_SKID_EN
  // Skid entry payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid <= {PW{1'b0}};
    end else if (w_clr) begin
      r_skid <= {PW{1'b0}};
    end else if (w_ld_skid) begin
      r_skid <= w_in_bus;
    end else begin
      r_skid <= r_skid;
    end
  end
`endif

endmodule

// File: doc/decode_exec_pipe.md
DECODE_EXEC_PIPE -- requirements
Module: decode_exec_pipe

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of 32-bit lanes per register operand (LANES=4 gives 128 bits).
REQ-002 The block SHALL have parameter CTRL_W, default 24, giving the width of the packed control-unit word.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port stall_all, input, 1: global freeze.
REQ-006 Port flush, input, 1: squash all held entries (bubble insert).
REQ-007 Ports in_valid (input, 1) and in_ready (output, 1): upstream (decode) handshake.
REQ-008 Input payload ports: in_instr (32), in_pc (32), in_pc_plus4 (32), in_imm (32), in_ctrl (CTRL_W), in_rd1 (LANES*32), in_rd2 (LANES*32), in_rd (5), in_rs1 (5), in_rs2 (5).
REQ-009 Ports out_valid (output, 1) and out_ready (input, 1): downstream (execute) handshake.
REQ-010 Output payload ports out_instr, out_pc, out_pc_plus4, out_imm, out_ctrl, out_rd1, out_rd2, out_rd, out_rs1 and out_rs2 SHALL each match the width of its in_ counterpart.
REQ-011 Port occupancy, output, 2: number of valid entries held.

Function
REQ-012 Accept SHALL occur when in_valid & in_ready; issue SHALL occur when out_valid & out_ready; a bundle is stored or dropped as a whole.
REQ-013 The block SHALL hold at most 2 entries (main + skid), with states EMPTY (0), ONE (1) and TWO (2).
REQ-014 Transitions: EMPTY->ONE on accept; ONE->TWO on accept without issue; ONE->EMPTY on issue without accept; ONE->ONE on accept with simultaneous issue; TWO->ONE on issue.
REQ-015 in_ready SHALL be a registered output equal to (state != TWO) & ~stall_all.
REQ-016 out_valid SHALL equal (state != EMPTY) & ~stall_all.
REQ-017 The out_* payload SHALL always present the oldest entry; order SHALL be strict FIFO.
REQ-018 Latency: a bundle accepted in cycle N SHALL be visible with out_valid=1 in cycle N+1 when the block was EMPTY.
REQ-019 In TWO, an issue SHALL promote the skid entry to main in the same edge, with no bubble.
REQ-020 flush with stall_all=0 SHALL, at the next edge, set state to EMPTY, zero all held payload (out_ctrl=0, out_rd=0, and so on), and drop any simultaneous in_valid bundle.
REQ-021 flush with stall_all=1 SHALL be ignored.
REQ-022 stall_all=1 SHALL freeze state and payload; no accept or issue occurs while it is asserted.
REQ-023 An entry with zero control SHALL be treated as an ordinary valid entry; bubbles SHALL be represented only by out_valid=0.
REQ-024 occupancy SHALL equal the state encoding (0, 1 or 2).

Reset
REQ-025 rst_n=0 SHALL asynchronously force state EMPTY and occupancy=0.
REQ-026 rst_n=0 SHALL force out_valid=0 and in_ready=0.
REQ-027 rst_n=0 SHALL zero every out_* payload bit.
REQ-028 After rst_n deasserts, in_ready SHALL rise at the first rising clk edge (stall_all=0).
REQ-029 Reset mid-operation SHALL discard all held entries.

Configuration
REQ-030 Macro DECODE_EXEC_PIPE_SKID_EN defined: REQ-013 to REQ-019 apply as written (2-entry, registered in_ready).
REQ-031 Macro DECODE_EXEC_PIPE_SKID_EN undefined: single-entry variant; state is EMPTY or ONE only; occupancy never exceeds 1; in_ready = ~stall_all & (state==EMPTY | out_ready), combinational; accept with simultaneous issue keeps state ONE; flush, reset and stall behaviour are unchanged.

Verification
REQ-032 Reset, then in_valid=1 with in_instr=0x00A00093 in cycle 1 -> cycle 2: out_valid=1, out_instr=0x00A00093, occupancy=1.
REQ-033 out_ready=0, push A=0x11 then B=0x22 -> occupancy=2, in_ready=0 next cycle; raise out_ready -> A issued, then B on the next cycle, no bubble.
REQ-034 State TWO, flush=1 with in_valid=1 (instr 0x33) -> next cycle occupancy=0, out_valid=0, out_ctrl=0; 0x33 is never issued.
REQ-035 State ONE, stall_all=1 and flush=1 for 3 cycles -> occupancy stays 1, payload unchanged; after release, the entry issues.
REQ-036 Streaming at in_valid=out_ready=1 for 16 cycles with LANES=4 and in_rd1=0xDEADBEEF replicated -> 16 issues in order, occupancy=1 throughout, out_rd1 matches bit-exact.
REQ-037 With occupancy=2, assert rst_n=0 between clock edges -> out_valid=0 and occupancy=0 immediately; neither entry issues after release.
